// File: rtl/decode_stage.sv
// RV64/RV32 integer+M decode stage: one output register plus one skid entry,
// decoding on acceptance so held results stay stable; saturating statistics.
module decode_stage #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [XLEN-1:0]  out_imm,
    output logic [3:0]       out_alu_op,
    output logic [5:0]       out_shamt,
    output logic             out_reg_write,
    output logic             out_illegal,
    output logic [CNT_W-1:0] decode_count,
    output logic [CNT_W-1:0] illegal_count
);

    localparam bit RV64 = (XLEN == 64);

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111, OPC_AUIPC  = 7'b0010111, OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011, OPC_OPIMM  = 7'b0010011, OPC_OP     = 7'b0110011,
        OPC_OPIMM32 = 7'b0011011, OPC_OP32  = 7'b0111011
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_NONE = 4'd0, ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV, ALU_XOR, ALU_AND,
        ALU_OR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_REM
    } alu_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_op;
        logic [5:0]      shamt;
        logic            reg_write;
        logic            illegal;
    } dec_t;

    function automatic alu_e base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic alu_e m_op(input logic [2:0] f3);
        if (!f3[2])     return ALU_MUL;
        else if (!f3[1]) return ALU_DIV;
        else            return ALU_REM;
    endfunction

    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] i_imm, s_imm, b_imm, u_imm, j_imm, sh_imm;

    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];
    assign i_imm  = {{52{in_instr[31]}}, in_instr[31:20]};
    assign s_imm  = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign b_imm  = {{52{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign u_imm  = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
    assign j_imm  = {{44{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign sh_imm = {58'b0, in_instr[25:20]};

    dec_t        dec;
    logic        ok, rw;
    alu_e        op;
    logic [63:0] imm64;

    always_comb begin
        ok    = 1'b0;
        rw    = 1'b0;
        op    = ALU_NONE;
        imm64 = '0;
        case (in_instr[6:0])
            OPC_LUI:    begin ok = 1'b1; rw = 1'b1; imm64 = u_imm; end
            OPC_AUIPC:  begin ok = 1'b1; rw = 1'b1; op = ALU_ADD; imm64 = u_imm; end
            OPC_JAL:    begin ok = 1'b1; rw = 1'b1; imm64 = j_imm; end
            OPC_JALR:   begin ok = (f3 == 3'b000); rw = 1'b1; imm64 = i_imm; end
            OPC_BRANCH: begin ok = (f3 != 3'b010) && (f3 != 3'b011); imm64 = b_imm; end
            OPC_LOAD: begin
                ok = (f3 != 3'b111) && (RV64 || ((f3 != 3'b011) && (f3 != 3'b110)));
                rw = 1'b1; op = ALU_ADD; imm64 = i_imm;
            end
            OPC_STORE: begin
                ok = !f3[2] && (RV64 || (f3 != 3'b011));
                op = ALU_ADD; imm64 = s_imm;
            end
            OPC_OPIMM: begin
                ok = 1'b1; rw = 1'b1; op = base_op(f3); imm64 = i_imm;
                // Shift immediates reuse the funct7 slot; shamt[5] only exists on RV64
                if (f3 == 3'b001) begin
                    ok = (in_instr[31:26] == 6'b000000) && (RV64 || !in_instr[25]);
                    imm64 = sh_imm;
                end else if (f3 == 3'b101) begin
                    ok = ((in_instr[31:26] == 6'b000000) || (in_instr[31:26] == 6'b010000))
                         && (RV64 || !in_instr[25]);
                    op = in_instr[30] ? ALU_SRA : ALU_SRL;
                    imm64 = sh_imm;
                end
            end
            OPC_OPIMM32: begin
                rw = 1'b1;
                case (f3)
                    3'b000:  begin ok = RV64; op = ALU_ADD; imm64 = i_imm; end
                    3'b001:  begin ok = RV64 && (f7 == 7'b0000000); op = ALU_SLL; imm64 = sh_imm; end
                    3'b101: begin
                        ok = RV64 && ((f7 == 7'b0000000) || (f7 == 7'b0100000));
                        op = in_instr[30] ? ALU_SRA : ALU_SRL;
                        imm64 = sh_imm;
                    end
                    default: ok = 1'b0;
                endcase
            end
            OPC_OP, OPC_OP32: begin
                rw = 1'b1;
                case (f7)
                    7'b0000000: begin ok = 1'b1; op = base_op(f3); end
                    7'b0100000: begin
                        ok = (f3 == 3'b000) || (f3 == 3'b101);
                        op = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
                    end
                    7'b0000001: begin ok = 1'b1; op = m_op(f3); end
                    default:    ok = 1'b0;
                endcase
                // Word forms: only add/sub/shifts and mul/div/rem exist, and only on RV64
                if (in_instr[6:0] == OPC_OP32) begin
                    if (f7 == 7'b0000001) ok = ok && RV64 && ((f3 == 3'b000) || f3[2]);
                    else                 ok = ok && RV64 &&
                                              ((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b101));
                end
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            op = ALU_NONE;
            rw = 1'b0;
        end
        dec           = '0;
        dec.pc        = in_pc;
        dec.rd        = in_instr[11:7];
        dec.rs1       = in_instr[19:15];
        dec.rs2       = in_instr[24:20];
        dec.imm       = imm64[XLEN-1:0];
        dec.alu_op    = op;
        dec.shamt     = in_instr[25:20];
        dec.reg_write = rw;
        dec.illegal   = !ok;
    end

    dec_t             out_q, out_d, skid_q, skid_d;
    logic             out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d, ill_cnt_q, ill_cnt_d;
    logic             in_fire, out_fire;

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        dec_cnt_d    = dec_cnt_q;
        ill_cnt_d    = ill_cnt_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            // in_ready_q implies an empty skid, so skid drain and in_fire never coincide
            if (out_fire || !out_valid_q) begin
                if (skid_valid_q) begin
                    out_d        = skid_q;
                    out_valid_d  = 1'b1;
                    skid_valid_d = 1'b0;
                end else if (in_fire) begin
                    out_d       = dec;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (in_fire) begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end
            if (out_fire) begin
                if (out_q.illegal) begin
                    if (ill_cnt_q != '1) ill_cnt_d = ill_cnt_q + 1'b1;
                end else begin
                    if (dec_cnt_q != '1) dec_cnt_d = dec_cnt_q + 1'b1;
                end
            end
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            dec_cnt_q    <= '0;
            ill_cnt_q    <= '0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            dec_cnt_q    <= dec_cnt_d;
            ill_cnt_q    <= ill_cnt_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_pc        = out_q.pc;
    assign out_rd        = out_q.rd;
    assign out_rs1       = out_q.rs1;
    assign out_rs2       = out_q.rs2;
    assign out_imm       = out_q.imm;
    assign out_alu_op    = out_q.alu_op;
    assign out_shamt     = out_q.shamt;
    assign out_reg_write = out_q.reg_write;
    assign out_illegal   = out_q.illegal;
    assign decode_count  = dec_cnt_q;
    assign illegal_count = ill_cnt_q;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 64, datapath width; legal values 32 and 64.
REQ-002 Parameter CNT_W, default 32, width of the statistics counters.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream offers an instruction.
REQ-006 in_ready  output  1  stage accepts the instruction this cycle.
REQ-007 in_instr  input  32  raw instruction word.
REQ-008 in_pc  input  XLEN  PC of in_instr.
REQ-009 flush  input  1  discard all held instructions.
REQ-010 out_valid  output  1  decoded result available.
REQ-011 out_ready  input  1  downstream consumes the result this cycle.
REQ-012 out_pc  output  XLEN  PC carried with the result.
REQ-013 out_rd, out_rs1, out_rs2  output  5 each  register fields instr[11:7], [19:15], [24:20].
REQ-014 out_imm  output  XLEN  sign-extended immediate.
REQ-015 out_alu_op  output  4  operation code per REQ-022.
REQ-016 out_shamt  output  6  instr[25:20].
REQ-017 out_reg_write  output  1  result writes rd.
REQ-018 out_illegal  output  1  instruction not decodable for this XLEN.
REQ-019 decode_count, illegal_count  output  CNT_W each  statistics counters.

Function
REQ-020 Decode covers opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, OP-IMM-32, OP-32 including M-extension funct7=0000001.
REQ-021 Immediates: I, S, B, U, J formats per RISC-V, sign-extended from the format's top bit to XLEN; U immediate on XLEN=64 sign-extended from bit 31; shift-immediates give {zeros, shamt}.
REQ-022 out_alu_op: 0 none, 1 add (ADD/ADDI/ADDW/ADDIW/AUIPC/LOAD/STORE address), 2 sub, 3 mul*, 4 div*, 5 xor, 6 and, 7 or, 8 sll, 9 srl, 10 sra, 11 slt, 12 sltu, 13 rem*; 14-15 unused.
REQ-023 out_reg_write=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, OP-IMM-32, OP-32; 0 for BRANCH, STORE, and any illegal instruction.
REQ-024 out_illegal=1, with alu_op=0 and reg_write=0, for: unknown opcode; unused funct3/funct7 combination; when XLEN=32: OP-32, OP-IMM-32, LD, LWU, SD, or shamt[5]=1.
REQ-025 Every accepted word is decoded exactly once regardless of value; consecutive identical words (including 0x00000013) are distinct instructions.
REQ-026 Latency: a word accepted in cycle N is presented on out_* in cycle N+1 at the earliest.
REQ-027 Storage: one output register plus one skid entry; sustained throughput one instruction per cycle with out_ready held high.
REQ-028 in_ready = skid entry empty; registered, independent of in_valid and out_ready in the same cycle.
REQ-029 Input handshake: in_valid&&in_ready; output handshake: out_valid&&out_ready.
REQ-030 While out_valid=1 and out_ready=0, all out_* remain stable; out_valid never drops without a handshake or flush.
REQ-031 Ordering: results leave in acceptance order; skid entry drains into output register on handshake.
REQ-032 Simultaneous output handshake and input handshake with skid empty: new word goes directly to output register.
REQ-033 flush: next cycle out_valid=0, skid empty, in_ready=1; an in_valid in the flush cycle is dropped; flush has priority over all handshakes.
REQ-034 decode_count +1 per output handshake with out_illegal=0; illegal_count +1 per output handshake with out_illegal=1; both saturate at all-ones.
REQ-035 Flushed instructions are not counted.

Reset
REQ-036 reset asserted: out_valid=0, in_ready=0, all out_* data fields 0, skid empty, both counters 0, effective immediately.
REQ-037 First posedge after reset deassertion: in_ready=1; reset mid-transfer discards all held instructions.

Verification
REQ-038 XLEN=64, in 0xFFF10093 (addi x1,x2,-1), out_ready=1 -> next cycle out_valid=1, rd=1, rs1=2, imm=0xFFFFFFFFFFFFFFFF, alu_op=1, reg_write=1, illegal=0.
REQ-039 XLEN=64, in 0x800001B7 (lui x3,0x80000) -> imm=0xFFFFFFFF80000000, rd=3, alu_op=0, reg_write=1.
REQ-040 XLEN=32, in 0x002081BB (addw) -> illegal=1, reg_write=0, alu_op=0, illegal_count=1, decode_count=0 after handshake.
REQ-041 out_ready=0, three back-to-back valid words A,B,C -> A on output, B in skid, in_ready=0 holding C; out_ready=1 -> A,B,C emerge in order, no loss or duplicate.
REQ-042 Output and skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, counters unchanged, dropped word never appears.
REQ-043 CNT_W=2, five legal words consumed -> decode_count=3 and stays 3; reset mid-stream -> counters 0, out_valid=0 immediately.
